// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake.
// Holds one instruction (control + datapath payload) between two pipeline
// stages. Bubbles present all-zero payloads. The optional macro
// PIPE_STAGE_SKID_EN adds a second (skid) entry so that in_ready becomes a
// register output with no combinational path from out_ready.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              outValid_q, outValid_d;
    logic [CTRL_W-1:0] outCtrl_q, outCtrl_d;
    logic [DATA_W-1:0] outData_q, outData_d;
    logic              acceptIn;
    logic              releaseOut;

    assign releaseOut = outValid_q && out_ready;
    assign acceptIn   = in_valid && in_ready;

    assign out_valid = outValid_q;
    assign out_ctrl  = outCtrl_q;
    assign out_data  = outData_q;

`ifdef PIPE_STAGE_SKID_EN

    logic              skidValid_q, skidValid_d;
    logic [CTRL_W-1:0] skidCtrl_q, skidCtrl_d;
    logic [DATA_W-1:0] skidData_q, skidData_d;
    logic              inReady_q, inReady_d;

    assign in_ready  = inReady_q;
    assign occupancy = {1'b0, outValid_q} + {1'b0, skidValid_q};

    // Next state for output and skid entries; skid only fills while the output entry is stalled.
    always_comb begin
        outValid_d  = outValid_q;
        outCtrl_d   = outCtrl_q;
        outData_d   = outData_q;
        skidValid_d = skidValid_q;
        skidCtrl_d  = skidCtrl_q;
        skidData_d  = skidData_q;
        if (flush) begin
            outValid_d  = 1'b0;
            outCtrl_d   = '0;
            outData_d   = '0;
            skidValid_d = 1'b0;
            skidCtrl_d  = '0;
            skidData_d  = '0;
        end else if (!outValid_q) begin
            if (acceptIn) begin
                outValid_d = 1'b1;
                outCtrl_d  = in_ctrl;
                outData_d  = in_data;
            end
        end else if (skidValid_q) begin
            if (releaseOut) begin
                outCtrl_d   = skidCtrl_q;
                outData_d   = skidData_q;
                skidValid_d = 1'b0;
                skidCtrl_d  = '0;
                skidData_d  = '0;
            end
        end else begin
            if (acceptIn && releaseOut) begin
                outCtrl_d = in_ctrl;
                outData_d = in_data;
            end else if (releaseOut) begin
                outValid_d = 1'b0;
                outCtrl_d  = '0;
                outData_d  = '0;
            end else if (acceptIn) begin
                skidValid_d = 1'b1;
                skidCtrl_d  = in_ctrl;
                skidData_d  = in_data;
            end
        end
        inReady_d = !skidValid_d;
    end

    // Skid entry and registered ready; ready comes out of reset asserted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skidValid_q <= 1'b0;
            skidCtrl_q  <= '0;
            skidData_q  <= '0;
            inReady_q   <= 1'b1;
        end else begin
            skidValid_q <= skidValid_d;
            skidCtrl_q  <= skidCtrl_d;
            skidData_q  <= skidData_d;
            inReady_q   <= inReady_d;
        end
    end

`else

    assign in_ready  = !outValid_q || out_ready;
    assign occupancy = {1'b0, outValid_q};

    // Next state for the single entry; a bubble always carries zero payloads.
    always_comb begin
        outValid_d = outValid_q;
        outCtrl_d  = outCtrl_q;
        outData_d  = outData_q;
        if (flush) begin
            outValid_d = 1'b0;
            outCtrl_d  = '0;
            outData_d  = '0;
        end else if (acceptIn) begin
            outValid_d = 1'b1;
            outCtrl_d  = in_ctrl;
            outData_d  = in_data;
        end else if (releaseOut) begin
            outValid_d = 1'b0;
            outCtrl_d  = '0;
            outData_d  = '0;
        end
    end

`endif

    // Output entry register, cleared asynchronously on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outValid_q <= 1'b0;
            outCtrl_q  <= '0;
            outData_q  <= '0;
        end else begin
            outValid_q <= outValid_d;
            outCtrl_q  <= outCtrl_d;
            outData_q  <= outData_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: directed scenarios followed by random traffic,
// checked by a scoreboard queue holding the words the stage should contain.
module tb_pipe_stage_reg;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 8;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } word_t;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;

    word_t expQ[$];
    int    checks = 0;
    int    failures = 0;
    bit    inReset = 1'b1;

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_ctrl(in_ctrl),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ctrl(out_ctrl),
        .out_data(out_data),
        .occupancy(occupancy)
    );

    // 10 time-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
        end
    endtask

    // Whether the stage should accept this cycle, from occupancy and capacity alone
    function automatic bit modelReady(input int held, input bit oReady);
        if (CAP == 1) return (held == 0) || oReady;
        return held < 2;
    endfunction

    // One clock cycle: drive at the falling edge, record the expected effect before the rising edge
    task automatic applyStimulus(input bit v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                                 input bit oReady, input bit fl);
        bit acc;
        @(negedge clk);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = oReady;
        flush     = fl;
        #1;
        acc = v && modelReady(expQ.size(), oReady);
        #3;
        if (fl) expQ.delete();
        else if (acc) expQ.push_back('{ctrl: c, data: d});
    endtask

    // Asynchronous reset in the middle of a stalled cycle
    task automatic resetMidCycle();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        #2;
        inReset = 1'b1;
        reset   = 1'b1;
        #1;
        checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("reset_out_ctrl", {56'd0, out_ctrl}, 64'd0);
        checkOutput("reset_out_data", {32'd0, out_data}, 64'd0);
        checkOutput("reset_occupancy", {62'd0, occupancy}, 64'd0);
        expQ.delete();
        @(negedge clk);
        #1;
        reset   = 1'b0;
        inReset = 1'b0;
    endtask

    // Monitor: compares outputs against the scoreboard each cycle, pops on release
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (!inReset) begin
                checkOutput("out_valid", {63'd0, out_valid}, {63'd0, expQ.size() > 0});
                checkOutput("occupancy", {62'd0, occupancy}, 64'(expQ.size()));
                checkOutput("in_ready", {63'd0, in_ready}, {63'd0, modelReady(expQ.size(), out_ready)});
                if (expQ.size() > 0) begin
                    checkOutput("out_ctrl", {56'd0, out_ctrl}, {56'd0, expQ[0].ctrl});
                    checkOutput("out_data", {32'd0, out_data}, {32'd0, expQ[0].data});
                    if (out_ready) void'(expQ.pop_front());
                end else begin
                    checkOutput("bubble_ctrl", {56'd0, out_ctrl}, 64'd0);
                    checkOutput("bubble_data", {32'd0, out_data}, 64'd0);
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        reset   = 1'b0;
        inReset = 1'b0;

        // Single word through an empty stage
        applyStimulus(1, 8'h5A, 32'h0000_1234, 1, 0);
        applyStimulus(0, 8'h00, 32'h0, 1, 0);
        applyStimulus(0, 8'h00, 32'h0, 1, 0);

        // Back-to-back stream
        for (int i = 1; i <= 4; i++) applyStimulus(1, 8'(i), 32'(i), 1, 0);
        repeat (3) applyStimulus(0, 8'h00, 32'h0, 1, 0);

        // Stall with a second word offered
        applyStimulus(1, 8'h0A, 32'hA, 0, 0);
        repeat (3) applyStimulus(1, 8'h0B, 32'hB, 0, 0);
        repeat (3) applyStimulus(0, 8'h00, 32'h0, 1, 0);

        // Flush with a simultaneous accept
        applyStimulus(1, 8'h11, 32'h11, 0, 0);
        applyStimulus(1, 8'h0C, 32'hC, 0, 1);
        repeat (2) applyStimulus(0, 8'h00, 32'h0, 1, 0);

        // Reset while stalled with words held
        applyStimulus(1, 8'h21, 32'h21, 0, 0);
        applyStimulus(1, 8'h22, 32'h22, 0, 0);
        resetMidCycle();
        repeat (3) applyStimulus(0, 8'h00, 32'h0, 1, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, 8'($urandom), $urandom,
                          $urandom_range(0, 9) < 7, $urandom_range(0, 24) == 0);
        end
        repeat (4) applyStimulus(0, 8'h00, 32'h0, 1, 0);

        @(negedge clk);
        #5;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32, width of the datapath payload (alu result, store data, pc+4, immediate, packed).
REQ-002 Parameter CTRL_W, default 8, width of the control payload (reg_write, mem_read, mem_write, mem_to_reg, write_register, packed).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 flush  input  1  synchronous kill of all held entries.
REQ-006 in_valid  input  1  upstream stage presents an instruction.
REQ-007 in_ready  output  1  stage can accept this cycle.
REQ-008 in_ctrl  input  CTRL_W  upstream control payload.
REQ-009 in_data  input  DATA_W  upstream datapath payload.
REQ-010 out_valid  output  1  stage holds a valid instruction for downstream.
REQ-011 out_ready  input  1  downstream accepts; low = stall.
REQ-012 out_ctrl  output  CTRL_W  registered control payload.
REQ-013 out_data  output  DATA_W  registered datapath payload.
REQ-014 occupancy  output  2  number of valid entries held (0..2).

Function
REQ-015 Accept SHALL occur iff in_valid && in_ready at a rising edge; release SHALL occur iff out_valid && out_ready.
REQ-016 Latency SHALL be exactly 1 cycle: a word accepted into an empty stage appears on out_* after that edge.
REQ-017 Words SHALL leave in acceptance order; none is dropped or duplicated except by flush/reset.
REQ-018 out_ctrl SHALL be all-zero whenever out_valid=0 (bubble = no side effects downstream); out_data SHALL be all-zero whenever out_valid=0.
REQ-019 While out_valid=1 and out_ready=0, out_ctrl/out_data SHALL hold stable.
REQ-020 Simultaneous accept and release on a one-entry-full stage SHALL replace the entry with no bubble (full throughput).
REQ-021 flush=1 SHALL, at the edge, invalidate all entries, zero out_ctrl/out_data, and set occupancy=0; a word accepted on the same edge SHALL be discarded.
REQ-022 flush SHALL take priority over accept and release; release on a flush cycle counts as delivered downstream (downstream's responsibility).
REQ-023 occupancy SHALL equal number of valid entries after each edge, never exceeding the compiled capacity.

Reset
REQ-024 On reset assertion, asynchronously: out_valid=0, out_ctrl=0, out_data=0, occupancy=0, all internal entries invalid and zero.
REQ-025 in_ready SHALL be 1 while reset is deasserted and the stage is empty, including the first cycle after reset release.
REQ-026 Reset asserted mid-stall SHALL discard all held words; no word SHALL reappear after release.

Configuration
REQ-027 Macro PIPE_STAGE_SKID_EN selects buffering.
REQ-028 Without PIPE_STAGE_SKID_EN: capacity 1; in_ready = !out_valid || out_ready (combinational from out_ready); occupancy in {0,1}.
REQ-029 With PIPE_STAGE_SKID_EN: capacity 2 (output entry + skid entry); in_ready SHALL be a register output equal to "skid entry empty", with no combinational path from out_ready.
REQ-030 With PIPE_STAGE_SKID_EN: accept while output entry full and out_ready=0 SHALL load the skid entry; on the next release the skid word SHALL move to the output entry in the same edge.
REQ-031 Both builds SHALL satisfy REQ-015..REQ-026 identically at the port level except in_ready timing and capacity.

Verification
REQ-032 Reset then in_valid=1, in_ctrl=0x5A, in_data=0x0000_1234, out_ready=1 -> next cycle out_valid=1, out_ctrl=0x5A, out_data=0x1234, occupancy=1.
REQ-033 Stream 4 words 0x1..0x4 back-to-back, out_ready=1 -> out_data 0x1..0x4 on 4 consecutive cycles, no bubble.
REQ-034 Word 0xA held, out_ready=0 for 3 cycles, in_valid=1 with 0xB -> no-skid: in_ready=0, out_data stays 0xA; skid: 0xB taken, occupancy=2, in_ready=0; out_ready=1 -> 0xA then 0xB.
REQ-035 occupancy=1, flush=1 with in_valid=1 (0xC) -> next cycle out_valid=0, out_ctrl=0, out_data=0, occupancy=0; 0xC never appears.
REQ-036 occupancy=2 (skid build) or 1, assert reset mid-cycle -> outputs zero immediately; after release in_ready=1, no stale word emitted.
